// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the register bank side and muldiv_unit.
// The master drives the operands and start. The slave returns busy/done and the 64-bit result.
interface muldiv_unit_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        dz;

  modport master (
    output start, op, a, b,
    input  busy, done, hi, lo, dz
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hi, lo, dz
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative 32x32 multiply (shift-add) / restoring divide returning a 64-bit hi/lo result.
// Define MULDIV_DIV_EN to build the divider; without it, DIV ops finish in one cycle with zero results.
module muldiv_unit (
  input  logic         clk,
  input  logic         rst,
  muldiv_unit_if.slave bus,
  output logic [1:0]   o_dbg_state
);
  // Handshake: start is taken on any rising edge where busy=0. a/b/op are sampled only on that edge.
  // done pulses for one cycle on the DONE entry. hi/lo/dz change only then and hold until the next done.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state, w_state_next;
  logic [5:0]  r_cnt;
  logic        r_skip;
  logic        r_neg_lo;
  logic [31:0] r_m;
  logic [63:0] r_acc;
  logic [31:0] r_hi, r_lo;
  logic        r_dz;

  logic        w_busy, w_accept, w_last;
  logic        w_sign_a, w_sign_b;
  logic [31:0] w_mag_a, w_mag_b;
  logic [32:0] w_sum;
  logic [63:0] w_mul_next, w_prod;
  logic [31:0] w_hi_res, w_lo_res;
  logic        w_dz_res;

`ifdef MULDIV_DIV_EN
  logic        r_is_div, r_neg_hi, r_bzero;
  logic [31:0] r_a_raw;
  logic [32:0] r_rem, w_rem_next;
  logic [33:0] w_trial;
  logic [31:0] w_quo_next;
`endif

  // A DIV that skips CALC spends its one cycle in CALC with busy low.
  assign w_busy   = (r_state == S_CALC) && !r_skip;
  assign w_accept = bus.start && !w_busy;
  assign w_last   = r_skip || (r_cnt == 6'd31);

  assign w_sign_a = bus.op[0] & bus.a[31];
  assign w_sign_b = bus.op[0] & bus.b[31];
  assign w_mag_a  = w_sign_a ? (32'd0 - bus.a) : bus.a;
  assign w_mag_b  = w_sign_b ? (32'd0 - bus.b) : bus.b;

  // Multiplier sits in r_acc[31:0] and shifts out as the partial product shifts in from the top.
  assign w_sum      = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_m} : 33'd0);
  assign w_mul_next = {w_sum, r_acc[31:1]};
  assign w_prod     = r_neg_lo ? (64'd0 - w_mul_next) : w_mul_next;

`ifdef MULDIV_DIV_EN
  // Dividend bits move from r_acc[31] into the remainder, and quotient bits fill r_acc from the bottom.
  assign w_trial    = {r_rem, r_acc[31]} - {2'b00, r_m};
  assign w_rem_next = w_trial[33] ? {r_rem[31:0], r_acc[31]} : w_trial[32:0];
  assign w_quo_next = {r_acc[30:0], ~w_trial[33]};
`endif

  always_comb begin
    w_hi_res = w_prod[63:32];
    w_lo_res = w_prod[31:0];
    w_dz_res = 1'b0;
`ifdef MULDIV_DIV_EN
    if (r_is_div) begin
      if (r_bzero) begin
        w_hi_res = r_a_raw;
        w_lo_res = 32'hFFFF_FFFF;
        w_dz_res = 1'b1;
      end else begin
        w_lo_res = r_neg_lo ? (32'd0 - w_quo_next) : w_quo_next;
        w_hi_res = r_neg_hi ? (32'd0 - w_rem_next[31:0]) : w_rem_next[31:0];
      end
    end
`else
    if (r_skip) begin
      w_hi_res = 32'd0;
      w_lo_res = 32'd0;
    end
`endif
  end

  always_comb begin
    w_state_next = r_state;
    if (w_accept) begin
      w_state_next = S_CALC;
    end else begin
      case (r_state)
        S_IDLE:  w_state_next = S_IDLE;
        S_CALC:  if (w_last) w_state_next = S_DONE;
        S_DONE:  w_state_next = S_IDLE;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= 6'd0;
      r_skip   <= 1'b0;
      r_neg_lo <= 1'b0;
      r_m      <= 32'd0;
      r_acc    <= 64'd0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_dz     <= 1'b0;
`ifdef MULDIV_DIV_EN
      r_is_div <= 1'b0;
      r_neg_hi <= 1'b0;
      r_bzero  <= 1'b0;
      r_a_raw  <= 32'd0;
      r_rem    <= 33'd0;
`endif
    end else if (w_accept) begin
      r_cnt    <= 6'd0;
      r_neg_lo <= w_sign_a ^ w_sign_b;
`ifdef MULDIV_DIV_EN
      r_skip   <= 1'b0;
      r_is_div <= bus.op[1];
      r_neg_hi <= w_sign_a;
      r_bzero  <= (bus.b == 32'd0);
      r_a_raw  <= bus.a;
      r_rem    <= 33'd0;
      if (bus.op[1]) begin
        r_m   <= w_mag_b;
        r_acc <= {32'd0, w_mag_a};
      end else begin
        r_m   <= w_mag_a;
        r_acc <= {32'd0, w_mag_b};
      end
`else
      r_skip   <= bus.op[1];
      r_m      <= w_mag_a;
      r_acc    <= {32'd0, w_mag_b};
`endif
    end else if (r_state == S_CALC) begin
      r_cnt <= r_cnt + 6'd1;
`ifdef MULDIV_DIV_EN
      if (r_is_div) begin
        r_acc <= {32'd0, w_quo_next};
        r_rem <= w_rem_next;
      end else begin
        r_acc <= w_mul_next;
      end
`else
      r_acc <= w_mul_next;
`endif
      if (w_last) begin
        r_hi <= w_hi_res;
        r_lo <= w_lo_res;
        r_dz <= w_dz_res;
      end
    end
  end

  assign bus.busy    = w_busy;
  assign bus.done    = (r_state == S_DONE);
  assign bus.hi      = r_hi;
  assign bus.lo      = r_lo;
  assign bus.dz      = r_dz;
  assign o_dbg_state = r_state;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: arithmetic model + per-cycle compare of busy/done/hi/lo/dz.
// Honours MULDIV_DIV_EN the same way as the design.
module tb_muldiv_unit;
  localparam int W = 65;
`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  // clock / reset
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;
  int         cyc = 0;

  muldiv_unit_if bus();
  muldiv_unit dut (.clk(clk), .rst(rst), .bus(bus), .o_dbg_state(dbg_state));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // scoreboard state
  logic [W-1:0] exp_q[$];
  int           due_q[$];
  bit           long_q[$];
  logic [W-1:0] held = '0;
  int           n_vec = 0, n_err = 0, n_done = 0, last_due = 0;
  logic         c_exp_done, c_exp_busy;

  task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h expected=%h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // {dz, hi, lo} from plain arithmetic on the operands
  function automatic logic [W-1:0] model(input logic [1:0] op_i, input logic [31:0] a_i,
                                         input logic [31:0] b_i);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a_i));
    sb = longint'($signed(b_i));
    case (op_i)
      2'b00: begin p = {32'd0, a_i} * {32'd0, b_i}; return {1'b0, p}; end
      2'b01: begin p = 64'(sa * sb); return {1'b0, p}; end
      default: begin
        if (!DIV_EN) return '0;
        if (b_i == 32'd0) return {1'b1, a_i, 32'hFFFF_FFFF};
        if (op_i == 2'b10) return {1'b0, a_i % b_i, a_i / b_i};
        q = sa / sb;
        r = sa % sb;
        return {1'b0, r[31:0], q[31:0]};
      end
    endcase
  endfunction

  function automatic int lat(input logic [1:0] op_i);
    return (op_i[1] && !DIV_EN) ? 1 : 32;
  endfunction

  // compare process: every cycle out of reset
  always @(negedge clk) begin
    if (!rst) begin
      c_exp_done = 1'b0;
      c_exp_busy = 1'b0;
      if (exp_q.size() > 0) begin
        c_exp_done = (cyc == due_q[0]);
        c_exp_busy = (cyc < due_q[0]) && long_q[0];
      end
      chk("busy", W'(bus.busy), W'(c_exp_busy));
      chk("done", W'(bus.done), W'(c_exp_done));
      if (bus.done) n_done++;
      if (c_exp_done) begin
        held = exp_q.pop_front();
        due_q.delete(0);
        long_q.delete(0);
      end
      chk("result", {bus.dz, bus.hi, bus.lo}, held);
    end
  end

  // driver: call at a negedge (or just after a posedge); returns just after the acceptance edge
  task automatic do_op(input logic [1:0] op_i, input logic [31:0] a_i, input logic [31:0] b_i);
    int guard = 0;
    while ((bus.busy || cyc < last_due) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_wait busy=%b expected idle by cycle %0d", bus.busy, last_due);
    end
    bus.start = 1'b1;
    bus.op    = op_i;
    bus.a     = a_i;
    bus.b     = b_i;
    @(posedge clk);
    #1;
    exp_q.push_back(model(op_i, a_i, b_i));
    due_q.push_back(cyc + lat(op_i));
    long_q.push_back(lat(op_i) > 1);
    last_due  = cyc + lat(op_i);
    bus.start = 1'b0;
    bus.op    = 2'($urandom_range(0, 3));
    bus.a     = $urandom;
    bus.b     = $urandom;
  endtask

  // returns at the negedge of the expected done cycle
  task automatic finish_op();
    int guard = 0;
    @(negedge clk);
    while (cyc < last_due && guard < 100) begin
      @(negedge clk);
      guard++;
    end
  endtask

  task automatic lit(input string nm, input logic [31:0] hi_e, input logic [31:0] lo_e,
                     input logic dz_e);
    chk(nm, {bus.dz, bus.hi, bus.lo}, {dz_e, hi_e, lo_e});
  endtask

  int base;

  initial begin
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = 32'd0;
    bus.b     = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", W'(bus.busy), '0);
    chk("reset_done", W'(bus.done), '0);
    lit("reset_out", 32'd0, 32'd0, 1'b0);

    do_op(2'b00, 32'd69, 32'd333);             finish_op(); lit("multu_69x333", 32'd0, 32'd22977, 1'b0);
    do_op(2'b01, 32'hFFFF_FFF9, 32'd98);       finish_op(); lit("mult_m7x98", 32'hFFFF_FFFF, 32'hFFFF_FD52, 1'b0);
    do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF); finish_op(); lit("multu_max", 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    do_op(2'b01, 32'h8000_0000, 32'h8000_0000); finish_op(); lit("mult_minsq", 32'h4000_0000, 32'd0, 1'b0);
`ifdef MULDIV_DIV_EN
    do_op(2'b10, 32'd45000, 32'd7);            finish_op(); lit("divu_45000_7", 32'd4, 32'd6428, 1'b0);
    do_op(2'b11, 32'hFFFF_B1E0, 32'd7);        finish_op(); lit("div_m20000_7", 32'hFFFF_FFFF, 32'hFFFF_F4D7, 1'b0);
    do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF); finish_op(); lit("div_ovf", 32'd0, 32'h8000_0000, 1'b0);
    do_op(2'b11, 32'd100, 32'hFFFF_FFF9);      finish_op(); lit("div_100_m7", 32'd2, 32'hFFFF_FFF2, 1'b0);
    do_op(2'b11, 32'hFFFF_FFFB, 32'd0);        finish_op(); lit("div_m5_0", 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1);
    do_op(2'b10, 32'd666, 32'd0);              finish_op(); lit("divu_666_0", 32'd666, 32'hFFFF_FFFF, 1'b1);
`else
    do_op(2'b10, 32'd9, 32'd3);                finish_op(); lit("divu_nodiv", 32'd0, 32'd0, 1'b0);
    do_op(2'b11, 32'd666, 32'd0);              finish_op(); lit("div_nodiv", 32'd0, 32'd0, 1'b0);
`endif
    // accepted in the DONE cycle of the previous op
    do_op(2'b00, 32'd3, 32'd5);                finish_op(); lit("multu_3x5_b2b", 32'd0, 32'd15, 1'b0);

    // reset mid-CALC aborts with no done
    do_op(2'b00, 32'd1080, 32'd720);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    due_q.delete();
    long_q.delete();
    held     = '0;
    last_due = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", W'(bus.busy), '0);
    chk("abort_done", W'(bus.done), '0);
    lit("abort_out", 32'd0, 32'd0, 1'b0);
    #1 base = n_done;
    repeat (40) @(negedge clk);
    #1 chk("abort_no_done", W'(n_done - base), '0);

    // a start pulse in mid-CALC is ignored
    base = n_done;
    do_op(2'b00, 32'd1080, 32'd720);
    repeat (5) @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'b01;
    bus.a     = $urandom;
    bus.b     = 32'd0;
    @(negedge clk);
    bus.start = 1'b0;
    finish_op();
    lit("multu_1080x720", 32'd0, 32'd777600, 1'b0);
    repeat (40) @(negedge clk);
    #1 chk("one_done", W'(n_done - base), W'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish by cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
